// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants and types for the button conditioner
//
// Purpose: default 12 MHz timing constants, channel index map, default
//          channel count, the auto-repeat state type and a small max helper.
// Ports:   none (package).

package btn_pkg;

  // Default channel count
  localparam int N_BTN_DEFAULT = 6;

  // Timing defaults for a 12 MHz clock
  localparam int DEB_20MS        = 240000;
  localparam int REP_DELAY_500MS = 6000000;
  localparam int REP_RATE_100MS  = 1200000;

  // Channel index map seen by the downstream traffic/speed logic
  localparam int BTN_TRIG     = 0;
  localparam int BTN_SPD_UP   = 1;
  localparam int BTN_SPD_DOWN = 2;
  localparam int BTN_MODE     = 3;
  localparam int BTN_M        = 4;
  localparam int BTN_SPARE    = 5;

  // Auto-repeat phase: idle (released or repeat disabled), waiting for the
  // first repeat, or emitting at the steady repeat rate.
  typedef enum logic [1:0] {
    REP_IDLE  = 2'd0,
    REP_DELAY = 2'd1,
    REP_RATE  = 2'd2
  } rep_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one synchronised, debounced button channel with auto-repeat
//
// Purpose: two-flop synchroniser, debounce counter and hold/repeat counter
//          for a single raw input.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   i_raw     in   asynchronous raw input
//   o_level   out  debounced level, 1 = pressed
//   o_press   out  one-cycle pulse on accepted 0->1
//   o_release out  one-cycle pulse on accepted 1->0
//   o_repeat  out  one-cycle auto-repeat pulse while held

module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = DEB_20MS,
  parameter int REPEAT_DELAY_CYC = REP_DELAY_500MS,
  parameter int REPEAT_RATE_CYC  = REP_RATE_100MS,
  parameter bit INV              = 1'b0,
  parameter bit REPEAT_EN        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
  localparam int HW = $clog2(max_int(REPEAT_DELAY_CYC, REPEAT_RATE_CYC)) + 1;

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY_CYC - 1);
  localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE_CYC - 1);

  logic          r_s1;
  logic          r_s2;
  logic [DW-1:0] r_deb_cnt;
  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic          r_repeat;
  rep_state_e    r_rep_state;
  logic [HW-1:0] r_hold_cnt;

  logic          w_accept;
  logic          w_press_now;
  logic          w_release_now;
  rep_state_e    w_rep_next;
  logic [HW-1:0] w_hold_next;
  logic          w_rep_fire;

  // The mismatch has lasted DEBOUNCE_CYC consecutive edges when the counter
  // sits at its terminal value and s2 still disagrees with the level.
  assign w_accept      = (r_s2 != r_level) && (r_deb_cnt == DEB_LAST);
  assign w_press_now   = w_accept &&  r_s2;
  assign w_release_now = w_accept && !r_s2;

  // Synchroniser and debounce
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_deb_cnt <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_s1      <= i_raw ^ INV;
      r_s2      <= r_s1;
      r_press   <= w_press_now;
      r_release <= w_release_now;
      if (r_s2 == r_level) begin
        r_deb_cnt <= '0;
      end else if (w_accept) begin
        r_level   <= r_s2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
    end
  end

  // Auto-repeat state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep_state <= REP_IDLE;
      r_hold_cnt  <= '0;
      r_repeat    <= 1'b0;
    end else begin
      r_rep_state <= w_rep_next;
      r_hold_cnt  <= w_hold_next;
      r_repeat    <= w_rep_fire;
    end
  end

  // Auto-repeat next-state. The press edge only arms the counter, so a repeat
  // can never coincide with a press; a release edge wins over a due repeat.
  always_comb begin
    w_rep_next  = r_rep_state;
    w_hold_next = r_hold_cnt;
    w_rep_fire  = 1'b0;
    case (r_rep_state)
      REP_IDLE: begin
        w_hold_next = '0;
        if (w_press_now && REPEAT_EN) begin
          w_rep_next = REP_DELAY;
        end
      end
      REP_DELAY: begin
        if (w_release_now) begin
          w_rep_next  = REP_IDLE;
          w_hold_next = '0;
        end else if (r_hold_cnt == DELAY_LAST) begin
          w_rep_fire  = 1'b1;
          w_hold_next = '0;
          w_rep_next  = REP_RATE;
        end else begin
          w_hold_next = r_hold_cnt + HW'(1);
        end
      end
      REP_RATE: begin
        if (w_release_now) begin
          w_rep_next  = REP_IDLE;
          w_hold_next = '0;
        end else if (r_hold_cnt == RATE_LAST) begin
          w_rep_fire  = 1'b1;
          w_hold_next = '0;
        end else begin
          w_hold_next = r_hold_cnt + HW'(1);
        end
      end
      default: begin
        w_rep_next  = REP_IDLE;
        w_hold_next = '0;
      end
    endcase
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - multi-channel button synchroniser, debouncer and repeater
//
// Purpose: N_BTN independent btn_channel instances between the raw board
//          buttons/switches and the traffic-state / speed-control logic.
// Ports:
//   clk          in   system clock, 12 MHz
//   rst          in   synchronous active-high reset
//   btn_raw      in   [N_BTN] asynchronous raw inputs
//   btn_level    out  [N_BTN] debounced level, 1 = pressed
//   btn_press    out  [N_BTN] one-cycle pulse per accepted 0->1
//   btn_release  out  [N_BTN] one-cycle pulse per accepted 1->0
//   btn_repeat   out  [N_BTN] one-cycle auto-repeat pulse while held

module btn_conditioner
  import btn_pkg::*;
#(
  parameter int               N_BTN            = N_BTN_DEFAULT,
  parameter int               DEBOUNCE_CYC     = DEB_20MS,
  parameter int               REPEAT_DELAY_CYC = REP_DELAY_500MS,
  parameter int               REPEAT_RATE_CYC  = REP_RATE_100MS,
  parameter logic [N_BTN-1:0] INV_MASK         = '0,
  parameter logic [N_BTN-1:0] REPEAT_MASK      = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYC     (DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC  (REPEAT_RATE_CYC),
      .INV              (INV_MASK[g]),
      .REPEAT_EN        (REPEAT_MASK[g])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_raw     (btn_raw[g]),
      .o_level   (btn_level[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g]),
      .o_repeat  (btn_repeat[g])
    );
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream input stage between the raw board push-buttons/switches and the traffic-state / speed-control logic.
- Per channel: synchronises the raw input, debounces it, and produces a clean level plus single-cycle press, release and auto-repeat pulses.
- Replaces ad-hoc single-register edge detection downstream. The speed logic consumes press|repeat on spd_up/spd_down; state_convert consumes the trig press pulse and the M/mode levels.

Parameters:
- N_BTN, 6, number of channels.
- DEBOUNCE_CYC, 240000, stable-mismatch cycles required to accept a new level (20 ms at 12 MHz); must be >= 2.
- REPEAT_DELAY_CYC, 6000000, cycles from press pulse to first repeat pulse (500 ms); must be >= 1.
- REPEAT_RATE_CYC, 1200000, cycles between subsequent repeat pulses (100 ms); must be >= 1.
- INV_MASK, {N_BTN{1'b0}}, bit i = 1 means raw input i is active-low and is inverted before synchronisation.
- REPEAT_MASK, {N_BTN{1'b0}}, bit i = 1 enables auto-repeat on channel i.

Ports:
- clk  input  1  system clock, 12 MHz.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  N_BTN  asynchronous raw button/switch inputs.
- btn_level  output  N_BTN  debounced level, 1 = pressed.
- btn_press  output  N_BTN  one-cycle pulse on each accepted 0->1 transition.
- btn_release  output  N_BTN  one-cycle pulse on each accepted 1->0 transition.
- btn_repeat  output  N_BTN  one-cycle auto-repeat pulse while held.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high: all state clears at the first clk edge with rst=1.
- Reset values: sync flops 0, debounce counters 0, btn_level 0, all pulse outputs 0, hold counters 0.
- After reset release, an input already held high is reported as a fresh press once debounced.
- Synchroniser: x = btn_raw[i] ^ INV_MASK[i], then two flops s1 -> s2. Only s2 is used downstream.
- Debounce, per channel:
  - If s2 != btn_level: cnt increments.
  - When cnt == DEBOUNCE_CYC-1 and the mismatch persists: btn_level <= s2, cnt <= 0. In the same edge, btn_press (new level 1) or btn_release (new level 0) is registered high for exactly one cycle.
  - If s2 == btn_level: cnt <= 0. Any glitch shorter than DEBOUNCE_CYC cycles produces no output change.
- Latency: if the new raw value is first captured into s1 at edge 0 and held, btn_level and the pulse update at edge DEBOUNCE_CYC+1.
- Pulses are registered outputs with no combinational path from btn_raw.
- Auto-repeat (REPEAT_MASK[i] = 1 only):
  - Hold counter clears on the press edge and counts while btn_level = 1.
  - First btn_repeat at edge P+REPEAT_DELAY_CYC, where P is the press edge. Subsequent pulses every REPEAT_RATE_CYC edges while held.
  - Release stops repeats immediately: no repeat in the release cycle or after it.
  - btn_repeat is never coincident with btn_press.
  - Channels with REPEAT_MASK[i] = 0 hold btn_repeat[i] at 0 permanently.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- Counter widths: $clog2 of the largest relevant parameter plus 1. Counters never wrap, because each reloads or clears at its terminal value.
- Reset mid-debounce or mid-hold: pending transitions are discarded and no pulse is emitted in the reset cycle or the cycle after.

Decomposition:
- Package btn_pkg:
  - Default timing constants for 12 MHz: DEB_20MS, REP_DELAY_500MS, REP_RATE_100MS.
  - Channel index constants: BTN_TRIG=0, BTN_SPD_UP=1, BTN_SPD_DOWN=2, BTN_MODE=3, BTN_M=4, BTN_SPARE=5.
  - Default N_BTN.
- Sub-module btn_channel: one synchroniser, debounce counter and repeat counter, plus four outputs. btn_conditioner is a generate loop of N_BTN instances.

Test Plan (sim params DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=10, REPEAT_RATE_CYC=3, REPEAT_MASK=6'b000110):
- Reset: rst=1 for 3 cycles with btn_raw=6'h3F -> all outputs 0 during reset. After release, level goes to 6'h3F with a press pulse 6'h3F at edge 5.
- Clean press on ch0: raw 0->1 captured at edge 0 -> btn_level[0]=1 and btn_press[0]=1 at edge 5 only. Release behaves symmetrically, giving one btn_release[0] pulse.
- Glitch rejection: ch0 raw high for 3 cycles then low -> btn_level, btn_press and btn_release stay 0 throughout.
- Auto-repeat on ch1 held 30 cycles after press edge P -> btn_repeat[1] pulses at P+10, P+13, P+16, and so on. Release then stops pulses. ch0 held the same duration shows no repeat.
- Active-low channel: INV_MASK=6'b100000, raw[5] driven 1->0 -> btn_press[5] asserted after the standard latency.
- Reset mid-debounce: assert rst at edge 3 of a ch2 press -> no press pulse. After rst drops, debounce restarts from 0 and requires a full 4 cycles.
